// File: rtl/npc_pkg.sv
// npc_pkg: shared NPC core constants, fetch FSM state encoding and filler instruction.
package npc_pkg;
  localparam int XLEN = 64;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;
endpackage

// File: rtl/ifu_pc_reg.sv
// ifu_pc_reg: fetch PC register; redirect load has priority over the +4 advance.
module ifu_pc_reg #(
  parameter int XLEN = npc_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = npc_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            inc,
  input  logic [XLEN-1:0] base,
  output logic [XLEN-1:0] pc
);
  always_ff @(posedge clk)
    if (rst) pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc;
    else if (inc) pc <= base + XLEN'(4);
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch stage with redirect squash.
// Optional IFU_PERF_CNT_EN adds delivered-fetch and dropped-response counters.
module ifu_fetch #(
  parameter int XLEN = npc_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = npc_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]     perf_fetch_cnt,
  output logic [63:0]     perf_drop_cnt
`endif
);
  import npc_pkg::*;
  state_t state, state_n;
  logic kill, up, hs, resp, drop;
  logic [XLEN-1:0] pc, fetch_pc;
  ifu_pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inc(resp && !kill),
    .base(fetch_pc),
    .pc(pc)
  );
  // up keeps the request channel quiet during the reset cycle itself
  assign imem_req_valid = up && state == S_REQ;
  assign imem_req_addr = pc;
  assign inst_valid = state == S_HOLD;
  assign hs = imem_req_valid && imem_req_ready;
  assign resp = state == S_WAIT && imem_resp_valid;
  assign drop = resp && (kill || redirect_valid);
  always_comb begin
    state_n = S_REQ;
    state_n = state == S_REQ  ? (hs ? S_WAIT : S_REQ) :
              state == S_WAIT ? (resp ? (drop ? S_REQ : S_HOLD) : S_WAIT) :
              state == S_HOLD ? ((redirect_valid || inst_ready) ? S_REQ : S_HOLD) : S_REQ;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_REQ;
      kill <= 1'b0;
      up <= 1'b0;
      fetch_pc <= '0;
      inst <= 32'h0;
      inst_pc <= '0;
    end else begin
      state <= state_n;
      up <= 1'b1;
      if (hs) fetch_pc <= pc;
      kill <= resp ? 1'b0 : kill | (redirect_valid && (state == S_WAIT || hs));
      if (resp && !drop) begin
        inst <= imem_resp_data;
        inst_pc <= fetch_pc;
      end
    end
`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk)
    if (rst) begin
      perf_fetch_cnt <= 64'h0;
      perf_drop_cnt <= 64'h0;
    end else begin
      if (inst_valid && inst_ready && !redirect_valid) perf_fetch_cnt <= perf_fetch_cnt + 64'h1;
      if (drop) perf_drop_cnt <= perf_drop_cnt + 64'h1;
    end
`endif
endmodule
